// File: rtl/branch_predict_fetch_if.sv
// Fetch-stage bus: execute-side redirect/training inputs and fetch-side PC/prediction outputs.
interface branch_predict_fetch_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  stall_f;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic [ADDR_WIDTH-1:0] PC_F;
    logic [ADDR_WIDTH-1:0] PCPlus4_F;
    logic                  pred_taken_F;
    logic [ADDR_WIDTH-1:0] pred_target_F;

    modport master (
        output stall_f, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  PC_F, PCPlus4_F, pred_taken_F, pred_target_F
    );

    modport slave (
        input  stall_f, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output PC_F, PCPlus4_F, pred_taken_F, pred_target_F
    );
endinterface

// File: rtl/branch_predict_fetch.sv
// Fetch PC register with a direct-mapped BTB and 2-bit saturating direction counters.
module branch_predict_fetch #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    BTB_ENTRIES = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_predict_fetch_if.slave bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX;

    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  pc_next;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]         lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_hit;
    logic                   lk_taken;

    logic [IDX-1:0]         up_idx;
    logic [TAG_W-1:0]       up_tag;
    logic                   up_hit;
    logic [1:0]             up_ctr_cur;
    logic [1:0]             up_ctr_nxt;
    logic                   wr_ctr;
    logic                   wr_target;
    logic                   wr_alloc;

    // Lookup: purely combinational from the registered PC.
    assign lk_idx   = pc_q[2 +: IDX];
    assign lk_tag   = pc_q[ADDR_WIDTH-1 -: TAG_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    assign bus.PC_F          = pc_q;
    assign bus.PCPlus4_F     = pc_plus4;
    assign bus.pred_taken_F  = lk_taken;
    assign bus.pred_target_F = lk_taken ? target_q[lk_idx] : pc_plus4;

    always_comb begin
        pc_next = pc_q;
        if (bus.redirect) begin
            pc_next = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (!bus.stall_f) begin
            pc_next = bus.pred_target_F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Training decode.
    assign up_idx     = bus.upd_pc[2 +: IDX];
    assign up_tag     = bus.upd_pc[ADDR_WIDTH-1 -: TAG_W];
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr_cur = ctr_q[up_idx];

    always_comb begin
        up_ctr_nxt = up_ctr_cur;
        wr_ctr     = 1'b0;
        wr_target  = 1'b0;
        wr_alloc   = 1'b0;
        if (bus.upd_valid) begin
            if (up_hit) begin
                wr_ctr = 1'b1;
                if (bus.upd_taken) begin
                    wr_target  = 1'b1;
                    up_ctr_nxt = (up_ctr_cur == 2'd3) ? 2'd3 : up_ctr_cur + 2'd1;
                end else begin
                    up_ctr_nxt = (up_ctr_cur == 2'd0) ? 2'd0 : up_ctr_cur - 2'd1;
                end
            end else if (bus.upd_taken) begin
                wr_ctr     = 1'b1;
                wr_target  = 1'b1;
                wr_alloc   = 1'b1;
                up_ctr_nxt = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= 2'd0;
            end
        end else begin
            if (wr_alloc) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (wr_ctr) begin
                ctr_q[up_idx] <= up_ctr_nxt;
            end
        end
    end

    // Tag/target storage has no reset; writes are still suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_alloc) begin
                tag_q[up_idx] <= up_tag;
            end
            if (wr_target) begin
                target_q[up_idx] <= {bus.upd_target[ADDR_WIDTH-1:2], 2'b00};
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed bench for branch_predict_fetch: free-run/wrap, allocation, hysteresis, aliasing, priority, reset.
module tb_branch_predict_fetch;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    branch_predict_fetch_if #(.ADDR_WIDTH(12)) bus ();

    branch_predict_fetch #(
        .ADDR_WIDTH (12),
        .BTB_ENTRIES(8),
        .RESET_PC   (12'h000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [11:0] addr);
        bus.redirect    = 1'b1;
        bus.redirect_pc = addr;
        step();
        bus.redirect    = 1'b0;
    endtask

    task automatic train(input logic [11:0] pc, input logic taken, input logic [11:0] target);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = target;
        step();
        bus.upd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (bus.PC_F !== 12'h000) begin n_bad++; $display("FAIL reset_pc: got %h expected %h", bus.PC_F, 12'h000); end
        n_cmp++; if (bus.PCPlus4_F !== 12'h004) begin n_bad++; $display("FAIL reset_pcplus4: got %h expected %h", bus.PCPlus4_F, 12'h004); end
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %b expected 0", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h004) begin n_bad++; $display("FAIL reset_target: got %h expected %h", bus.pred_target_F, 12'h004); end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        logic [11:0] exp_pc;
        for (int i = 0; i < 1030; i++) begin
            exp_pc = 12'(i * 4);
            n_cmp++; if (bus.PC_F !== exp_pc) begin n_bad++; $display("FAIL freerun_pc[%0d]: got %h expected %h", i, bus.PC_F, exp_pc); end
            n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL freerun_taken[%0d]: got %b expected 0", i, bus.pred_taken_F); end
            if (exp_pc == 12'hFFC) begin
                n_cmp++; if (bus.PCPlus4_F !== 12'h000) begin n_bad++; $display("FAIL wrap_pcplus4: got %h expected %h", bus.PCPlus4_F, 12'h000); end
            end
            step();
        end
    endtask

    task automatic test_alloc();
        train(12'h010, 1'b1, 12'h040);
        goto(12'h010);
        n_cmp++; if (bus.pred_taken_F !== 1'b1) begin n_bad++; $display("FAIL alloc_taken: got %b expected 1", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h040) begin n_bad++; $display("FAIL alloc_target: got %h expected %h", bus.pred_target_F, 12'h040); end
        step();
        n_cmp++; if (bus.PC_F !== 12'h040) begin n_bad++; $display("FAIL alloc_follow: got %h expected %h", bus.PC_F, 12'h040); end
    endtask

    task automatic test_hysteresis();
        train(12'h010, 1'b0, 12'h000);
        goto(12'h010);
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL hyst_weak_taken: got %b expected 0", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h014) begin n_bad++; $display("FAIL hyst_weak_target: got %h expected %h", bus.pred_target_F, 12'h014); end
        step();
        n_cmp++; if (bus.PC_F !== 12'h014) begin n_bad++; $display("FAIL hyst_weak_next: got %h expected %h", bus.PC_F, 12'h014); end
        train(12'h010, 1'b1, 12'h040);
        train(12'h010, 1'b1, 12'h040);
        train(12'h010, 1'b0, 12'h000);
        goto(12'h010);
        n_cmp++; if (bus.pred_taken_F !== 1'b1) begin n_bad++; $display("FAIL hyst_strong_taken: got %b expected 1", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h040) begin n_bad++; $display("FAIL hyst_strong_target: got %h expected %h", bus.pred_target_F, 12'h040); end
    endtask

    task automatic test_aliasing();
        train(12'h030, 1'b1, 12'h080);
        goto(12'h010);
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL alias_evicted: got %b expected 0", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h014) begin n_bad++; $display("FAIL alias_evicted_target: got %h expected %h", bus.pred_target_F, 12'h014); end
        goto(12'h030);
        n_cmp++; if (bus.pred_taken_F !== 1'b1) begin n_bad++; $display("FAIL alias_new_taken: got %b expected 1", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h080) begin n_bad++; $display("FAIL alias_new_target: got %h expected %h", bus.pred_target_F, 12'h080); end
        train(12'h050, 1'b0, 12'h000);
        goto(12'h030);
        n_cmp++; if (bus.pred_taken_F !== 1'b1) begin n_bad++; $display("FAIL alias_nt_miss_taken: got %b expected 1", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h080) begin n_bad++; $display("FAIL alias_nt_miss_target: got %h expected %h", bus.pred_target_F, 12'h080); end
    endtask

    task automatic test_priority();
        bus.stall_f     = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 12'h103;
        step();
        bus.redirect    = 1'b0;
        n_cmp++; if (bus.PC_F !== 12'h100) begin n_bad++; $display("FAIL prio_redirect: got %h expected %h", bus.PC_F, 12'h100); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.PC_F !== 12'h100) begin n_bad++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, bus.PC_F, 12'h100); end
            n_cmp++; if (bus.pred_target_F !== 12'h104) begin n_bad++; $display("FAIL stall_target[%0d]: got %h expected %h", i, bus.pred_target_F, 12'h104); end
        end
        bus.stall_f = 1'b0;
        step();
        n_cmp++; if (bus.PC_F !== 12'h104) begin n_bad++; $display("FAIL stall_release: got %h expected %h", bus.PC_F, 12'h104); end
    endtask

    task automatic test_back_to_back();
        goto(12'h060);
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL b2b_pre_taken: got %b expected 0", bus.pred_taken_F); end
        train(12'h060, 1'b1, 12'h203);
        n_cmp++; if (bus.PC_F !== 12'h064) begin n_bad++; $display("FAIL b2b_no_bypass: got %h expected %h", bus.PC_F, 12'h064); end
        goto(12'h060);
        n_cmp++; if (bus.pred_taken_F !== 1'b1) begin n_bad++; $display("FAIL b2b_post_taken: got %b expected 1", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h200) begin n_bad++; $display("FAIL b2b_target_align: got %h expected %h", bus.pred_target_F, 12'h200); end
    endtask

    task automatic test_reset_mid();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 12'h300;
        bus.stall_f     = 1'b1;
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = 12'h070;
        bus.upd_taken   = 1'b1;
        bus.upd_target  = 12'h100;
        reset           = 1'b1;
        step();
        reset         = 1'b0;
        bus.redirect  = 1'b0;
        bus.stall_f   = 1'b0;
        bus.upd_valid = 1'b0;
        n_cmp++; if (bus.PC_F !== 12'h000) begin n_bad++; $display("FAIL midreset_pc: got %h expected %h", bus.PC_F, 12'h000); end
        goto(12'h030);
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL midreset_030: got %b expected 0", bus.pred_taken_F); end
        goto(12'h060);
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL midreset_060: got %b expected 0", bus.pred_taken_F); end
        goto(12'h070);
        n_cmp++; if (bus.pred_taken_F !== 1'b0) begin n_bad++; $display("FAIL midreset_070: got %b expected 0", bus.pred_taken_F); end
        n_cmp++; if (bus.pred_target_F !== 12'h074) begin n_bad++; $display("FAIL midreset_070_target: got %h expected %h", bus.pred_target_F, 12'h074); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        reset           = 1'b1;
        bus.stall_f     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = '0;
        test_reset();
        test_free_run();
        test_reset();
        test_alloc();
        test_hysteresis();
        test_aliasing();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
